// File: rtl/u_2_2_window_ctrl.sv
// Sequencing controller for the 2x2 window stage: line buffer, frame position and window-valid tracking.
// Optional protocol-error pulse on a mid-frame start of frame: define U22_CTRL_FRAME_ERR_EN.
module u_2_2_window_ctrl #(
   parameter int unsigned IMG_WIDTH  = 640,
   parameter int unsigned IMG_HEIGHT = 480
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          in_valid,
   input  logic                          in_sof,
   input  logic [7:0]                    in_data,
   output logic                          ce,
   output logic [7:0]                    data_line_0,
   output logic [7:0]                    data_line_1,
   output logic                          win_valid,
   output logic [$clog2(IMG_WIDTH)-1:0]  win_x,
   output logic [$clog2(IMG_HEIGHT)-1:0] win_y,
`ifdef U22_CTRL_FRAME_ERR_EN
   output logic                          frame_done,
   output logic                          frame_err
`else
   output logic                          frame_done
`endif
);

   localparam int unsigned XW = $clog2(IMG_WIDTH);
   localparam int unsigned YW = $clog2(IMG_HEIGHT);
   localparam int unsigned DW = 8;
   localparam logic [XW-1:0] XLAST = XW'(IMG_WIDTH - 1);
   localparam logic [YW-1:0] YLAST = YW'(IMG_HEIGHT - 1);

   typedef enum logic {IDLE, ACTIVE} state_e;

   state_e          state_q, state_d;
   logic [XW-1:0]   col_q, col_d;
   logic [YW-1:0]   row_q, row_d;
   logic [DW-1:0]   line_mem [IMG_WIDTH];

   logic            accept_c;
   logic [XW-1:0]   pix_x_c;
   logic [YW-1:0]   pix_y_c;
   logic            last_c;
   logic            win_c;

   logic            ce_q;
   logic [DW-1:0]   dl0_q, dl1_q;
   logic            p1_win_q, p1_done_q;
   logic [XW-1:0]   p1_x_q;
   logic [YW-1:0]   p1_y_q;
   logic            win_valid_q, frame_done_q;
   logic [XW-1:0]   win_x_q;
   logic [YW-1:0]   win_y_q;

   // State register
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next state: a start of frame opens a frame, the last pixel closes it
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept_c) state_d = ACTIVE;
         ACTIVE:  if (accept_c && last_c) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Pixel acceptance and position; a start of frame always forces (0,0)
   always_comb begin
      accept_c = 1'b0;
      pix_x_c  = '0;
      pix_y_c  = '0;
      case (state_q)
         IDLE:    accept_c = in_valid & in_sof;
         ACTIVE:  accept_c = in_valid;
         default: accept_c = 1'b0;
      endcase
      if (!in_sof) begin
         pix_x_c = col_q;
         pix_y_c = row_q;
      end
      last_c = (pix_x_c == XLAST) && (pix_y_c == YLAST);
      win_c  = (pix_x_c != '0) && (pix_y_c != '0);
   end

   // Position counters advance past the accepted pixel
   always_comb begin
      col_d = col_q;
      row_d = row_q;
      if (accept_c) begin
         if (last_c) begin
            col_d = '0;
            row_d = '0;
         end else if (pix_x_c == XLAST) begin
            col_d = '0;
            row_d = pix_y_c + YW'(1);
         end else begin
            col_d = pix_x_c + XW'(1);
            row_d = pix_y_c;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         col_q <= '0;
         row_q <= '0;
      end else begin
         col_q <= col_d;
         row_q <= row_d;
      end
   end

   // Line buffer is never cleared; nonblocking read of the old entry gives read-before-write
   always_ff @(posedge clk) begin
      if (accept_c && !rst) line_mem[pix_x_c] <= in_data;
   end

   // Stage 1 feeds the window stage, stage 2 lines up with its registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         ce_q         <= 1'b0;
         dl0_q        <= '0;
         dl1_q        <= '0;
         p1_win_q     <= 1'b0;
         p1_done_q    <= 1'b0;
         p1_x_q       <= '0;
         p1_y_q       <= '0;
         win_valid_q  <= 1'b0;
         frame_done_q <= 1'b0;
         win_x_q      <= '0;
         win_y_q      <= '0;
      end else begin
         ce_q      <= accept_c;
         p1_win_q  <= accept_c & win_c;
         p1_done_q <= accept_c & last_c;
         if (accept_c) begin
            dl0_q  <= in_data;
            dl1_q  <= (pix_y_c == '0) ? '0 : line_mem[pix_x_c];
            p1_x_q <= pix_x_c;
            p1_y_q <= pix_y_c;
         end
         win_valid_q  <= p1_win_q;
         frame_done_q <= p1_done_q;
         if (ce_q) begin
            win_x_q <= p1_x_q;
            win_y_q <= p1_y_q;
         end
      end
   end

   assign ce          = ce_q;
   assign data_line_0 = dl0_q;
   assign data_line_1 = dl1_q;
   assign win_valid   = win_valid_q;
   assign win_x       = win_x_q;
   assign win_y       = win_y_q;
   assign frame_done  = frame_done_q;

`ifdef U22_CTRL_FRAME_ERR_EN
   logic restart_c;
   logic p1_err_q, frame_err_q;

   // A start of frame while a frame is open means the previous frame was truncated
   assign restart_c = accept_c & in_sof & (state_q == ACTIVE);

   always_ff @(posedge clk) begin
      if (rst) begin
         p1_err_q    <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         p1_err_q    <= restart_c;
         frame_err_q <= p1_err_q;
      end
   end

   assign frame_err = frame_err_q;
`endif

endmodule

// File: tb/tb_u_2_2_window_ctrl.sv
// Directed bench for u_2_2_window_ctrl on a 4x3 image; checks line data at N+1 and window flags at N+2.
module tb_u_2_2_window_ctrl;

   localparam int unsigned W = 4;
   localparam int unsigned H = 3;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic       in_sof = 1'b0;
   logic [7:0] in_data = 8'd0;
   logic       ce;
   logic [7:0] data_line_0, data_line_1;
   logic       win_valid;
   logic [1:0] win_x;
   logic [1:0] win_y;
   logic       frame_done;
`ifdef U22_CTRL_FRAME_ERR_EN
   logic       frame_err;
`endif

   int         errors = 0;
   int         checks = 0;
   int         prev_pix = -1;
   logic [7:0] last_dl0 = 8'd0;
   logic [7:0] last_dl1 = 8'd0;

   u_2_2_window_ctrl #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_sof      (in_sof),
      .in_data     (in_data),
      .ce          (ce),
      .data_line_0 (data_line_0),
      .data_line_1 (data_line_1),
      .win_valid   (win_valid),
      .win_x       (win_x),
      .win_y       (win_y),
`ifdef U22_CTRL_FRAME_ERR_EN
      .frame_done  (frame_done),
      .frame_err   (frame_err)
`else
      .frame_done  (frame_done)
`endif
   );

   always #5 clk = ~clk;

   task automatic drive(input logic v, input logic so, input logic [7:0] d);
      in_valid = v;
      in_sof   = so;
      in_data  = d;
      @(posedge clk);
      #1;
   endtask

   // Feeds npix pixels of a frame (value base+i+1), gap idle cycles after each, optional drain.
   task automatic run_frame(input int gap, input int base, input int npix,
                            input bit tail, input bit restart, input string tag);
      int         q[$];
      int         s, x, y;
      logic [7:0] e0, e1;
      bit         ew, ed;
      for (int i = 0; i < npix; i++) begin
         q.push_back(i);
         for (int g = 0; g < gap; g++) q.push_back(-1);
      end
      if (tail) begin
         q.push_back(-1);
         q.push_back(-1);
      end
      for (int k = 0; k < q.size(); k++) begin
         s = q[k];
         if (s >= 0) drive(1'b1, s == 0, 8'(base + s + 1));
         else        drive(1'b0, 1'b0, 8'd0);
         checks++;
         if (s >= 0) begin
            e0 = 8'(base + s + 1);
            e1 = (s / int'(W) == 0) ? 8'd0 : 8'(base + s - 3);
            if (ce !== 1'b1 || data_line_0 !== e0 || data_line_1 !== e1) begin
               errors++;
               $display("FAIL %s line px%0d: ce=%0b l0=%0d l1=%0d, want ce=1 l0=%0d l1=%0d",
                        tag, s, ce, data_line_0, data_line_1, e0, e1);
            end
            last_dl0 = e0;
            last_dl1 = e1;
         end else if (ce !== 1'b0 || data_line_0 !== last_dl0 || data_line_1 !== last_dl1) begin
            errors++;
            $display("FAIL %s idle slot%0d: ce=%0b l0=%0d l1=%0d, want ce=0 l0=%0d l1=%0d",
                     tag, k, ce, data_line_0, data_line_1, last_dl0, last_dl1);
         end
         checks++;
         if (prev_pix >= 0) begin
            x  = prev_pix % int'(W);
            y  = prev_pix / int'(W);
            ew = (x >= 1) && (y >= 1);
            ed = (prev_pix == int'(W * H) - 1);
            if (win_valid !== ew || frame_done !== ed ||
                (ew && (win_x !== 2'(x) || win_y !== 2'(y)))) begin
               errors++;
               $display("FAIL %s window px%0d: wv=%0b x=%0d y=%0d done=%0b, want wv=%0b x=%0d y=%0d done=%0b",
                        tag, prev_pix, win_valid, win_x, win_y, frame_done, ew, x, y, ed);
            end
         end else if (win_valid !== 1'b0 || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL %s window idle slot%0d: wv=%0b done=%0b, want 0 0",
                     tag, k, win_valid, frame_done);
         end
`ifdef U22_CTRL_FRAME_ERR_EN
         checks++;
         if (frame_err !== (restart && k == 1)) begin
            errors++;
            $display("FAIL %s frame_err slot%0d: got %0b want %0b", tag, k, frame_err, restart && k == 1);
         end
`endif
         prev_pix = s;
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      drive(1'b0, 1'b0, 8'd0);
      drive(1'b1, 1'b1, 8'd9);
      checks++;
      if ({ce, data_line_0, data_line_1, win_valid, win_x, win_y, frame_done} !== 23'd0) begin
         errors++;
         $display("FAIL reset outputs: ce=%0b l0=%0d l1=%0d wv=%0b x=%0d y=%0d done=%0b, want all 0",
                  ce, data_line_0, data_line_1, win_valid, win_x, win_y, frame_done);
      end
`ifdef U22_CTRL_FRAME_ERR_EN
      checks++;
      if (frame_err !== 1'b0) begin
         errors++;
         $display("FAIL reset frame_err: got %0b want 0", frame_err);
      end
`endif
      rst      = 1'b0;
      prev_pix = -1;
      last_dl0 = 8'd0;
      last_dl1 = 8'd0;
   endtask

   task automatic test_frame;
      run_frame(0, 0, 12, 1'b1, 1'b0, "frame");
   endtask

   task automatic test_no_sof;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b0, 8'(77 + i));
         checks++;
         if (ce !== 1'b0 || win_valid !== 1'b0) begin
            errors++;
            $display("FAIL no_sof drop%0d: ce=%0b wv=%0b, want 0 0", i, ce, win_valid);
         end
      end
      drive(1'b0, 1'b0, 8'd0);
      run_frame(0, 0, 12, 1'b1, 1'b0, "after_drop");
   endtask

   task automatic test_gap;
      run_frame(1, 20, 12, 1'b1, 1'b0, "gap");
   endtask

   task automatic test_sof_restart;
      run_frame(0, 0, 6, 1'b0, 1'b0, "pre_sof");
      run_frame(0, 49, 12, 1'b1, 1'b1, "restart");
   endtask

   task automatic test_reset_mid;
      run_frame(0, 0, 9, 1'b0, 1'b0, "pre_rst");
      rst = 1'b1;
      drive(1'b1, 1'b0, 8'd10);
      checks++;
      if ({ce, data_line_0, data_line_1, win_valid, win_x, win_y, frame_done} !== 23'd0) begin
         errors++;
         $display("FAIL mid_reset outputs: ce=%0b l0=%0d l1=%0d wv=%0b x=%0d y=%0d done=%0b, want all 0",
                  ce, data_line_0, data_line_1, win_valid, win_x, win_y, frame_done);
      end
      rst = 1'b0;
      drive(1'b1, 1'b0, 8'd11);
      checks++;
      if (ce !== 1'b0 || win_valid !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset idle: ce=%0b wv=%0b, want 0 0", ce, win_valid);
      end
      prev_pix = -1;
      last_dl0 = 8'd0;
      last_dl1 = 8'd0;
      run_frame(0, 0, 12, 1'b1, 1'b0, "post_rst");
   endtask

   task automatic test_back_to_back;
      run_frame(0, 0, 12, 1'b0, 1'b0, "b2b_a");
      run_frame(0, 100, 12, 1'b1, 1'b0, "b2b_b");
   endtask

   initial begin
      test_reset();
      test_frame();
      test_no_sof();
      test_gap();
      test_sof_restart();
      test_reset_mid();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
